// File: rtl/loop_nest_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : loop_nest_controller_pkg
// Brief    : FSM encoding and parameter helpers shared by the loop-nest files.
// Revision : 1.0
// ============================================================================
package loop_nest_controller_pkg;

  localparam int         c_STATE_W = 2;
  localparam logic [1:0] c_S_IDLE  = 2'd0;
  localparam logic [1:0] c_S_RUN   = 2'd1;
  localparam logic [1:0] c_S_FIN   = 2'd2;

  // True when an id field of width id_w can address every one of num_loops levels.
  function automatic bit id_width_ok(input int num_loops, input int id_w);
    return (num_loops >= 1) && (id_w >= 1) && (id_w < 31) &&
           (num_loops <= (1 << id_w));
  endfunction

endpackage
`default_nettype wire

// File: rtl/loop_nest_controller_loop_counter_stage.sv
`default_nettype none
// ============================================================================
// Module   : loop_counter_stage
// Brief    : One nest level: max-iter register, counter, first/last, carry.
// Revision : 1.0
// ============================================================================
module loop_counter_stage
  import loop_nest_controller_pkg::*;
#(
  parameter int LOOP_ITER_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_wr_en,
  input  logic [LOOP_ITER_W-1:0] i_wr_data,
  input  logic                   i_carry_in,
  input  logic                   i_clear,
  input  logic                   i_active,
  output logic [LOOP_ITER_W-1:0] o_count,
  output logic                   o_first,
  output logic                   o_last,
  output logic                   o_carry_out
);

  logic [LOOP_ITER_W-1:0] r_max;
  logic [LOOP_ITER_W-1:0] r_count;
  logic                   w_last;

  // Inactive levels look permanently last so carries pass straight through them.
  assign w_last = !i_active || (r_count == r_max);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_max   <= '0;
      r_count <= '0;
    end else begin
      if (i_wr_en) begin
        r_max <= i_wr_data;
      end
      if (i_clear || !i_active) begin
        r_count <= '0;
      end else if (i_carry_in) begin
        r_count <= w_last ? '0 : r_count + LOOP_ITER_W'(1);
      end
    end
  end

  assign o_count     = r_count;
  assign o_first     = (r_count == '0);
  assign o_last      = w_last;
  assign o_carry_out = i_carry_in & w_last;

endmodule
`default_nettype wire

// File: rtl/loop_nest_controller.sv
`default_nettype none
// ============================================================================
// Module   : loop_nest_controller
// Brief    : Sequences a nest of counted loops, one inner step per handshake.
// Revision : 1.0
// ============================================================================
module loop_nest_controller
  import loop_nest_controller_pkg::*;
#(
  parameter int NUM_LOOPS   = 8,
  parameter int LOOP_ID_W   = 3,
  parameter int LOOP_ITER_W = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             cfg_loop_iter_v,
  input  logic [LOOP_ITER_W-1:0]           cfg_loop_iter,
  input  logic [LOOP_ID_W-1:0]             cfg_loop_iter_loop_id,
  input  logic                             start,
  input  logic                             abort,
  output logic                             busy,
  output logic                             done,
  output logic                             aborted,
  output logic                             cfg_err,
  output logic                             step_valid,
  input  logic                             step_ready,
  output logic [NUM_LOOPS*LOOP_ITER_W-1:0] loop_iter_vec,
  output logic [NUM_LOOPS-1:0]             loop_first_vec,
  output logic [NUM_LOOPS-1:0]             loop_last_vec,
  output logic [LOOP_ID_W-1:0]             loop_exit_level,
  output logic                             loop_exit_any
);

  localparam bit c_ID_W_OK = id_width_ok(NUM_LOOPS, LOOP_ID_W);

  logic [c_STATE_W-1:0] r_state;
  logic [LOOP_ID_W-1:0] r_max_loop_ptr;
  logic                 r_aborted;
  logic                 r_cfg_err;

  logic                 w_idle;
  logic                 w_run;
  logic                 w_id_ok;
  logic                 w_cfg_wr;
  logic                 w_handshake;
  logic                 w_final;
  logic                 w_clear;
  logic [NUM_LOOPS:0]   w_carry;
  logic [NUM_LOOPS-1:0] w_active;
  logic [NUM_LOOPS-1:0] w_wr_en;
  logic [NUM_LOOPS-1:0] w_first;
  logic [NUM_LOOPS-1:0] w_last;
  logic [LOOP_ID_W-1:0] w_exit_level;
  logic                 w_prefix;

  assign w_idle      = (r_state == c_S_IDLE);
  assign w_run       = (r_state == c_S_RUN);
  assign w_id_ok     = c_ID_W_OK && (32'(cfg_loop_iter_loop_id) < NUM_LOOPS);
  assign w_cfg_wr    = cfg_loop_iter_v && w_idle && w_id_ok;
  // Abort wins over a same-cycle handshake: the step is not consumed.
  assign w_handshake = w_run && step_ready && !abort;
  assign w_clear     = !w_run || abort;
  assign w_carry[0]  = w_handshake;
  assign w_final     = w_carry[NUM_LOOPS];

  for (genvar i = 0; i < NUM_LOOPS; i++) begin : g_stage
    assign w_active[i] = (i <= 32'(r_max_loop_ptr));
    assign w_wr_en[i]  = w_cfg_wr && (32'(cfg_loop_iter_loop_id) == i);

    loop_counter_stage #(
      .LOOP_ITER_W(LOOP_ITER_W)
    ) u_stage (
      .clk        (clk),
      .reset      (reset),
      .i_wr_en    (w_wr_en[i]),
      .i_wr_data  (cfg_loop_iter),
      .i_carry_in (w_carry[i]),
      .i_clear    (w_clear),
      .i_active   (w_active[i]),
      .o_count    (loop_iter_vec[i*LOOP_ITER_W +: LOOP_ITER_W]),
      .o_first    (w_first[i]),
      .o_last     (w_last[i]),
      .o_carry_out(w_carry[i+1])
    );
  end

  // Highest active level whose whole sub-nest (levels 0..k) is at its last value.
  always_comb begin
    w_exit_level = '0;
    w_prefix     = 1'b1;
    for (int k = 0; k < NUM_LOOPS; k++) begin
      w_prefix = w_prefix & w_last[k];
      if (w_prefix && w_active[k]) begin
        w_exit_level = LOOP_ID_W'(k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= c_S_IDLE;
      r_max_loop_ptr <= '0;
      r_aborted      <= 1'b0;
      r_cfg_err      <= 1'b0;
    end else begin
      r_aborted <= abort && !w_idle;
      r_cfg_err <= cfg_loop_iter_v && (!w_idle || !w_id_ok);
      if (w_cfg_wr) begin
        r_max_loop_ptr <= cfg_loop_iter_loop_id;
      end
      case (r_state)
        c_S_IDLE: if (start) r_state <= c_S_RUN;
        c_S_RUN: begin
          if (abort)        r_state <= c_S_IDLE;
          else if (w_final) r_state <= c_S_FIN;
        end
        c_S_FIN:  r_state <= c_S_IDLE;
        default:  r_state <= c_S_IDLE;
      endcase
    end
  end

  assign busy            = !w_idle;
  assign done            = (r_state == c_S_FIN);
  assign aborted         = r_aborted;
  assign cfg_err         = r_cfg_err;
  assign step_valid      = w_run;
  assign loop_first_vec  = busy ? w_first : '0;
  assign loop_last_vec   = busy ? w_last : '0;
  assign loop_exit_level = w_run ? w_exit_level : '0;
  assign loop_exit_any   = w_run && w_last[0];

endmodule
`default_nettype wire

// File: tb/tb_loop_nest_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_loop_nest_controller
// Brief    : Directed tables, corner sequences and a random run vs. an index model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_loop_nest_controller;

  localparam int NL  = 5;
  localparam int IDW = 3;
  localparam int IW  = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             cfg_v;
  logic [IW-1:0]    cfg_iter;
  logic [IDW-1:0]   cfg_id;
  logic             start, abort, step_ready;
  logic             busy, done, aborted, cfg_err, step_valid;
  logic [NL*IW-1:0] loop_iter_vec;
  logic [NL-1:0]    loop_first_vec, loop_last_vec;
  logic [IDW-1:0]   loop_exit_level;
  logic             loop_exit_any;

  always #5 clk = ~clk;

  loop_nest_controller #(.NUM_LOOPS(NL), .LOOP_ID_W(IDW), .LOOP_ITER_W(IW)) dut (
    .clk(clk), .reset(reset),
    .cfg_loop_iter_v(cfg_v), .cfg_loop_iter(cfg_iter), .cfg_loop_iter_loop_id(cfg_id),
    .start(start), .abort(abort),
    .busy(busy), .done(done), .aborted(aborted), .cfg_err(cfg_err),
    .step_valid(step_valid), .step_ready(step_ready),
    .loop_iter_vec(loop_iter_vec), .loop_first_vec(loop_first_vec),
    .loop_last_vec(loop_last_vec), .loop_exit_level(loop_exit_level),
    .loop_exit_any(loop_exit_any)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cfg_v = 0; cfg_iter = '0; cfg_id = '0; start = 0; abort = 0; step_ready = 0;
  endtask

  task automatic do_reset();
    reset = 1; idle_inputs(); tick(); tick(); reset = 0;
  endtask

  task automatic cfg(input int id, input int val);
    cfg_v = 1; cfg_id = IDW'(id); cfg_iter = IW'(val); tick(); cfg_v = 0;
  endtask

  task automatic pulse_start();
    start = 1; tick(); start = 0;
  endtask

  task automatic run_to_done(input string tag, input int exp_steps);
    int steps = 0;
    bit seen = 0;
    step_ready = 1;
    for (int c = 0; c < 200 && !seen; c++) begin
      if (done) seen = 1;
      else begin
        if (step_valid) steps++;
        tick();
      end
    end
    chk({tag, ".done_seen"}, 64'(seen), 64'd1);
    chk({tag, ".steps"}, 64'(steps), 64'(exp_steps));
    step_ready = 0;
    tick();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic          rdy;
    logic          vld;
    logic          dn;
    int            c0, c1, c2;
    logic [NL-1:0] last;
    int            lvl;
    logic          any;
  } row_t;

  function automatic row_t mk(logic rdy, logic vld, logic dn, int c0, int c1, int c2,
                              logic [NL-1:0] last, int lvl, logic any);
    row_t r;
    r.rdy = rdy; r.vld = vld; r.dn = dn; r.c0 = c0; r.c1 = c1; r.c2 = c2;
    r.last = last; r.lvl = lvl; r.any = any;
    return r;
  endfunction

  task automatic check_row(input string tag, input row_t r);
    logic [NL*IW-1:0] e;
    e = '0;
    e[0 +: IW] = IW'(r.c0);
    e[IW +: IW] = IW'(r.c1);
    e[2*IW +: IW] = IW'(r.c2);
    chk({tag, ".valid"}, 64'(step_valid), 64'(r.vld));
    chk({tag, ".done"}, 64'(done), 64'(r.dn));
    chk({tag, ".busy"}, 64'(busy), 64'(r.vld | r.dn));
    chk({tag, ".iter"}, 64'(loop_iter_vec), 64'(e));
    chk({tag, ".last"}, 64'(loop_last_vec), 64'(r.last));
    chk({tag, ".lvl"}, 64'(loop_exit_level), 64'(r.lvl));
    chk({tag, ".any"}, 64'(loop_exit_any), 64'(r.any));
  endtask

  // ---------------- reference model ----------------
  // The nest position is a single step index; each level's counter is one
  // mixed-radix digit of it.
  int m_state;
  int m_mx[NL];
  int m_ptr, m_idx;
  bit m_ab, m_ce;

  function automatic int m_span(int k);
    int p = 1;
    for (int j = 0; j < k; j++) p = p * (m_mx[j] + 1);
    return p;
  endfunction

  function automatic int m_digit(int i);
    if (m_state != 1 || i > m_ptr) return 0;
    return (m_idx / m_span(i)) % (m_mx[i] + 1);
  endfunction

  task automatic model_reset();
    m_state = 0; m_ptr = 0; m_idx = 0; m_ab = 0; m_ce = 0;
    for (int i = 0; i < NL; i++) m_mx[i] = 0;
  endtask

  task automatic model_check(input string tag);
    logic [NL*IW-1:0] e_iter;
    logic [NL-1:0] e_first, e_last;
    int e_lvl;
    bit bz, rn;
    bz = (m_state != 0);
    rn = (m_state == 1);
    e_iter = '0; e_first = '0; e_last = '0; e_lvl = 0;
    for (int i = 0; i < NL; i++) begin
      e_iter[i*IW +: IW] = IW'(m_digit(i));
      if (bz) begin
        e_first[i] = (m_digit(i) == 0);
        e_last[i]  = (i > m_ptr) || (m_digit(i) == m_mx[i]);
      end
    end
    if (rn)
      for (int k = 0; k <= m_ptr; k++)
        if ((m_idx + 1) % m_span(k + 1) == 0) e_lvl = k;
    chk({tag, ".busy"}, 64'(busy), 64'(bz));
    chk({tag, ".valid"}, 64'(step_valid), 64'(rn));
    chk({tag, ".done"}, 64'(done), 64'(m_state == 2));
    chk({tag, ".aborted"}, 64'(aborted), 64'(m_ab));
    chk({tag, ".cfg_err"}, 64'(cfg_err), 64'(m_ce));
    chk({tag, ".iter"}, 64'(loop_iter_vec), 64'(e_iter));
    chk({tag, ".first"}, 64'(loop_first_vec), 64'(e_first));
    chk({tag, ".last"}, 64'(loop_last_vec), 64'(e_last));
    chk({tag, ".lvl"}, 64'(loop_exit_level), 64'(e_lvl));
    chk({tag, ".any"}, 64'(loop_exit_any), 64'(rn && ((m_idx + 1) % (m_mx[0] + 1) == 0)));
  endtask

  task automatic model_advance();
    bit bz;
    int id;
    bz = (m_state != 0);
    id = int'(cfg_id);
    m_ab = abort && bz;
    m_ce = cfg_v && (bz || id >= NL);
    if (cfg_v && !bz && id < NL) begin
      m_mx[id] = int'(cfg_iter);
      m_ptr = id;
    end
    case (m_state)
      0: if (start) begin m_state = 1; m_idx = 0; end
      1: begin
        if (abort) m_state = 0;
        else if (step_ready) begin
          if (m_idx == m_span(m_ptr + 1) - 1) m_state = 2;
          else m_idx++;
        end
      end
      default: m_state = 0;
    endcase
  endtask

  // ---------------- test sequence ----------------
  row_t t2[$];
  row_t t3[$];

  initial begin
    t2.push_back(mk(1, 1, 0, 0, 0, 0, 5'b11100, 0, 0));
    t2.push_back(mk(1, 1, 0, 1, 0, 0, 5'b11101, 0, 1));
    t2.push_back(mk(1, 1, 0, 0, 1, 0, 5'b11100, 0, 0));
    t2.push_back(mk(1, 1, 0, 1, 1, 0, 5'b11101, 0, 1));
    t2.push_back(mk(1, 1, 0, 0, 2, 0, 5'b11110, 0, 0));
    t2.push_back(mk(1, 1, 0, 1, 2, 0, 5'b11111, 2, 1));
    t2.push_back(mk(0, 0, 1, 0, 0, 0, 5'b11100, 0, 0));
    t2.push_back(mk(0, 0, 0, 0, 0, 0, 5'b00000, 0, 0));
    // Ready 1,0,1,0...: each step is shown again on the stalled cycle.
    t3.push_back(t2[0]);
    for (int s = 1; s < 6; s++) begin
      row_t r;
      r = t2[s]; r.rdy = 0; t3.push_back(r);
      r.rdy = 1; t3.push_back(r);
    end
    t3.push_back(t2[6]);
    t3.push_back(t2[7]);

    do_reset();
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.iter", 64'(loop_iter_vec), 64'd0);
    chk("rst.first", 64'(loop_first_vec), 64'd0);
    chk("rst.last", 64'(loop_last_vec), 64'd0);

    // T1: single level, max 2
    cfg(0, 2);
    pulse_start();
    for (int s = 0; s < 3; s++) begin
      step_ready = 1;
      chk($sformatf("t1.valid%0d", s), 64'(step_valid), 64'd1);
      chk($sformatf("t1.iter%0d", s), 64'(loop_iter_vec), 64'(s));
      chk($sformatf("t1.any%0d", s), 64'(loop_exit_any), 64'(s == 2));
      chk($sformatf("t1.lvl%0d", s), 64'(loop_exit_level), 64'd0);
      chk($sformatf("t1.done%0d", s), 64'(done), 64'd0);
      tick();
    end
    step_ready = 0;
    chk("t1.done", 64'(done), 64'd1);
    tick();
    chk("t1.idle", 64'(busy | done), 64'd0);

    // T2 / T3: three levels, max = [1,2,0]
    do_reset();
    cfg(0, 1); cfg(1, 2); cfg(2, 0);
    pulse_start();
    foreach (t2[i]) begin
      step_ready = t2[i].rdy;
      check_row($sformatf("t2[%0d]", i), t2[i]);
      tick();
    end
    pulse_start();
    foreach (t3[i]) begin
      step_ready = t3[i].rdy;
      check_row($sformatf("t3[%0d]", i), t3[i]);
      tick();
    end

    // T4: abort on the 4th step, then rerun
    pulse_start();
    step_ready = 1;
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("t4.nodone%0d", s), 64'(done), 64'd0);
      tick();
    end
    abort = 1;
    chk("t4.iter_at_abort", 64'(loop_iter_vec), 64'(16'h0101));
    tick();
    abort = 0; step_ready = 0;
    chk("t4.aborted", 64'(aborted), 64'd1);
    chk("t4.busy", 64'(busy), 64'd0);
    chk("t4.done", 64'(done), 64'd0);
    chk("t4.iter", 64'(loop_iter_vec), 64'd0);
    tick();
    chk("t4.aborted_pulse", 64'(aborted), 64'd0);
    pulse_start();
    chk("t4.rerun_iter", 64'(loop_iter_vec), 64'd0);
    run_to_done("t4.rerun", 6);

    // T5: cfg while busy, then out-of-range id in IDLE
    pulse_start();
    cfg(1, 7);
    chk("t5.err_busy", 64'(cfg_err), 64'd1);
    tick();
    chk("t5.err_pulse", 64'(cfg_err), 64'd0);
    run_to_done("t5.run1", 6);
    cfg(NL, 3);
    chk("t5.err_id", 64'(cfg_err), 64'd1);
    pulse_start();
    run_to_done("t5.run2", 6);

    // T6: reset mid-run, then start with cleared cfg
    pulse_start();
    step_ready = 1;
    tick(); tick();
    reset = 1; tick(); reset = 0; step_ready = 0;
    chk("t6.outs", 64'({busy, done, aborted, cfg_err, step_valid, loop_exit_any}), 64'd0);
    chk("t6.iter", 64'(loop_iter_vec), 64'd0);
    chk("t6.flags", 64'({loop_first_vec, loop_last_vec, loop_exit_level}), 64'd0);
    pulse_start();
    step_ready = 1;
    chk("t6.valid", 64'(step_valid), 64'd1);
    chk("t6.last", 64'(loop_last_vec), 64'h1f);
    chk("t6.any", 64'(loop_exit_any), 64'd1);
    tick();
    step_ready = 0;
    chk("t6.done", 64'(done), 64'd1);
    tick();
    chk("t6.idle", 64'(busy), 64'd0);

    // Random traffic against the index model
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 2500; cyc++) begin
      cfg_v      = ($urandom % 8) == 0;
      cfg_id     = IDW'($urandom % 8);
      cfg_iter   = IW'($urandom % 4);
      start      = ($urandom % 4) == 0;
      abort      = ($urandom % 64) == 0;
      step_ready = ($urandom % 4) != 0;
      model_check($sformatf("rnd%0d", cyc));
      model_advance();
      tick();
    end
    idle_inputs();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
